// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO.
// Configurable width, parity, stop bits and depth.
module uart_tx_fifo #(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [DATA_BITS-1:0]              in_data,
    output logic                              in_ready,
    output logic                              ser_tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              frame_done
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CCW = $clog2(CLOCKS_PER_BIT);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0]  FULL     = CW'(FIFO_DEPTH);
    localparam logic [CCW-1:0] CNT_LAST = CCW'(CLOCKS_PER_BIT - 1);
    localparam logic [BW-1:0]  DAT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]  STP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic [CCW-1:0]       clk_cnt, clk_cnt_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] sr, sr_n;
    logic [DATA_BITS-1:0] word, word_n;
    logic                 ser_d;
    logic                 par_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count, count_n;

    logic bit_end;
    logic last_stop;
    logic push;
    logic pop;

    assign bit_end   = (clk_cnt == CNT_LAST);
    assign last_stop = (state == S_STOP) && bit_end
                       && (bit_idx == STP_LAST);
    assign push      = in_valid && in_ready;
    assign pop       = (count != '0)
                       && ((state == S_IDLE) || last_stop);
    assign count_n   = count + CW'(push) - CW'(pop);

    assign busy       = (state != S_IDLE) || (count != '0);
    assign fifo_count = count;
    assign frame_done = last_stop;

    // FIFO storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_n;
            in_ready <= (count_n != FULL);
        end
    end

    // FSM state, counters, shifter and line register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            sr      <= '0;
            word    <= '0;
            ser_tx  <= 1'b1;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_idx <= bit_idx_n;
            sr      <= sr_n;
            word    <= word_n;
            ser_tx  <= ser_d;
        end
    end

    // Next state; line level is derived from next state
    always_comb begin
        state_n   = state;
        clk_cnt_n = bit_end ? '0 : clk_cnt + 1'b1;
        bit_idx_n = bit_idx;
        sr_n      = sr;
        word_n    = word;
        unique case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                if (pop) begin
                    state_n = S_START;
                    sr_n    = mem[rd_ptr];
                    word_n  = mem[rd_ptr];
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n   = S_DATA;
                    bit_idx_n = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    sr_n = sr >> 1;
                    if (bit_idx == DAT_LAST) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY != 0) ? S_PARITY
                                                  : S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n   = S_STOP;
                    bit_idx_n = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        bit_idx_n = '0;
                        if (pop) begin
                            state_n = S_START;
                            sr_n    = mem[rd_ptr];
                            word_n  = mem[rd_ptr];
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        par_bit = (PARITY == 2) ? ^word_n : ~^word_n;

        ser_d = 1'b1;
        unique case (state_n)
            S_START:  ser_d = 1'b0;
            S_DATA:   ser_d = sr_n[0];
            S_PARITY: ser_d = par_bit;
            default:  ser_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo.
// Three configurations driven from one clock.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic [7:0] da = '0, dbv = '0;
    logic [4:0] dc = '0;
    logic       ra, rb, rc;
    logic       txa, txb, txc;
    logic       ba, bb, bc;
    logic       fda, fdb, fdc;
    logic [2:0] cna, cnb, cnc;

    uart_tx_fifo u_a (
        .clk(clk), .rst(rst),
        .in_valid(va), .in_data(da), .in_ready(ra),
        .ser_tx(txa), .busy(ba),
        .fifo_count(cna), .frame_done(fda)
    );

    uart_tx_fifo #(.PARITY(2)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(vb), .in_data(dbv), .in_ready(rb),
        .ser_tx(txb), .busy(bb),
        .fifo_count(cnb), .frame_done(fdb)
    );

    uart_tx_fifo #(.DATA_BITS(5), .STOP_BITS(2), .PARITY(1)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(vc), .in_data(dc), .in_ready(rc),
        .ser_tx(txc), .busy(bc),
        .fifo_count(cnc), .frame_done(fdc)
    );

    int checks = 0;
    int errors = 0;
    bit cap = 1'b0;
    int first_bad;

    bit qa_tx[$], qa_fd[$];
    bit qb_tx[$], qb_fd[$];
    bit qc_tx[$], qc_fd[$];
    bit got_tx[$], got_fd[$];
    bit exp_tx[$], exp_fd[$];
    int dec_q[$];

    // Record every line and pulse sample just after each edge
    always @(posedge clk) begin
        #1;
        if (cap) begin
            qa_tx.push_back(txa); qa_fd.push_back(fda);
            qb_tx.push_back(txb); qb_fd.push_back(fdb);
            qc_tx.push_back(txc); qc_fd.push_back(fdc);
        end
    end

    task automatic add_idle();
        exp_tx.push_back(1'b1);
        exp_fd.push_back(1'b0);
    endtask

    task automatic add_frame(input int w, input int nd,
                             input int par, input int ns);
        bit bits[$];
        int ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            bits.push_back(((w >> i) & 1) == 1);
            ones += (w >> i) & 1;
        end
        if (par == 2) bits.push_back(ones % 2 == 1);
        if (par == 1) bits.push_back(ones % 2 == 0);
        for (int i = 0; i < ns; i++) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < CPB; c++) begin
                exp_tx.push_back(bits[k]);
                exp_fd.push_back(k == bits.size() - 1 && c == CPB - 1);
            end
        end
    endtask

    function automatic int n_diff();
        int n;
        int len;
        bit et, ef;
        n = 0;
        first_bad = -1;
        len = (got_tx.size() > exp_tx.size()) ? got_tx.size()
                                                : exp_tx.size();
        for (int i = 0; i < len; i++) begin
            et = (i < exp_tx.size()) ? exp_tx[i] : 1'b1;
            ef = (i < exp_fd.size()) ? exp_fd[i] : 1'b0;
            if (i >= got_tx.size() || got_tx[i] !== et
                || got_fd[i] !== ef) begin
                if (first_bad < 0) first_bad = i;
                n++;
            end
        end
        return n;
    endfunction

    function automatic int fd_pulses();
        int n;
        n = 0;
        foreach (got_fd[i]) if (got_fd[i]) n++;
        return n;
    endfunction

    function automatic int decode(input int nd, input int par,
                                  input int ns);
        int bad, i, nb, w, ones;
        bit b;
        bad = 0;
        i = 0;
        nb = 1 + nd + ((par != 0) ? 1 : 0) + ns;
        dec_q.delete();
        while (i < got_tx.size()) begin
            if (got_tx[i] == 1'b1) begin
                if (got_fd[i]) bad++;
                i++;
            end else if (i + nb * CPB > got_tx.size()) begin
                bad++;
                i = got_tx.size();
            end else begin
                w = 0;
                ones = 0;
                for (int k = 0; k < nb; k++) begin
                    b = got_tx[i + k * CPB];
                    for (int c = 1; c < CPB; c++)
                        if (got_tx[i + k * CPB + c] !== b) bad++;
                    if (k == 0) begin
                        if (b) bad++;
                    end else if (k <= nd) begin
                        w = w | (int'(b) << (k - 1));
                        ones += int'(b);
                    end else if (par != 0 && k == nd + 1) begin
                        if ((ones + int'(b)) % 2 != ((par == 1) ? 1 : 0))
                            bad++;
                    end else begin
                        if (!b) bad++;
                    end
                end
                for (int c = 0; c < nb * CPB; c++)
                    if (got_fd[i + c] != (c == nb * CPB - 1)) bad++;
                dec_q.push_back(w);
                i += nb * CPB;
            end
        end
        return bad;
    endfunction

    task automatic push_a(input logic [7:0] v);
        bit acc;
        int g;
        g = 0;
        @(negedge clk);
        va = 1'b1;
        da = v;
        do begin
            acc = ra;
            @(posedge clk);
            if (!acc) @(negedge clk);
            g++;
        end while (!acc && g < 2000);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_a_timeout got ready=%0b want 1", ra);
        end
    endtask

    task automatic push_b(input logic [7:0] v);
        bit acc;
        int g;
        g = 0;
        @(negedge clk);
        vb = 1'b1;
        dbv = v;
        do begin
            acc = rb;
            @(posedge clk);
            if (!acc) @(negedge clk);
            g++;
        end while (!acc && g < 2000);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_b_timeout got ready=%0b want 1", rb);
        end
    endtask

    task automatic push_c(input logic [4:0] v);
        bit acc;
        int g;
        g = 0;
        @(negedge clk);
        vc = 1'b1;
        dc = v;
        do begin
            acc = rc;
            @(posedge clk);
            if (!acc) @(negedge clk);
            g++;
        end while (!acc && g < 2000);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_c_timeout got ready=%0b want 1", rc);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        #2;
        while ((ba || bb || bc || va || vb || vc) && n < 5000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 5000) begin
            checks++; errors++;
            $display("FAIL idle_timeout got busy=%0b%0b%0b want 000",
                     ba, bb, bc);
        end
    endtask

    task automatic start_cap();
        @(posedge clk);
        #2;
        qa_tx.delete(); qa_fd.delete();
        qb_tx.delete(); qb_fd.delete();
        qc_tx.delete(); qc_fd.delete();
        exp_tx.delete(); exp_fd.delete();
        cap = 1'b1;
    endtask

    task automatic stop_cap();
        wait_idle();
        repeat (4) @(posedge clk);
        #2;
        cap = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            bad = 0;
            if (txa !== 1'b1 || ra !== 1'b1 || ba !== 1'b0) bad++;
            if (cna !== 3'd0 || fda !== 1'b0) bad++;
            if (txb !== 1'b1 || rb !== 1'b1 || bb !== 1'b0) bad++;
            if (cnb !== 3'd0 || fdb !== 1'b0) bad++;
            if (txc !== 1'b1 || rc !== 1'b1 || bc !== 1'b0) bad++;
            if (cnc !== 3'd0 || fdc !== 1'b0) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL reset_values got %0d bad fields want 0",
                         bad);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (txa !== 1'b1 || ba !== 1'b0 || fda !== 1'b0) bad++;
            if (txb !== 1'b1 || bb !== 1'b0 || fdb !== 1'b0) bad++;
            if (txc !== 1'b1 || bc !== 1'b0 || fdc !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_line got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        push_a(8'hA5);
        @(negedge clk);
        va = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (ba !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy got %0b want 1", ba);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (txa !== 1'b1 || cna !== 3'd0 || ba !== 1'b0
            || fda !== 1'b0 || ra !== 1'b1) begin
            errors++;
            $display("FAIL midreset_abort got tx=%0b cnt=%0d busy=%0b want 1 0 0",
                     txa, cna, ba);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (txa !== 1'b1 || ba !== 1'b0 || fda !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midreset_quiet got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_even_parity();
        int d;
        start_cap();
        push_b(8'h55);
        @(negedge clk);
        vb = 1'b0;
        stop_cap();
        got_tx = qb_tx;
        got_fd = qb_fd;
        add_idle();
        add_frame(8'h55, 8, 2, 1);
        d = n_diff();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL even_wave got %0d bad samples (first %0d) want 0",
                     d, first_bad);
        end
        checks++;
        if (got_tx.size() <= 44 || got_tx[37] !== 1'b0) begin
            errors++;
            $display("FAIL even_parity_bit got %0b want 0",
                     (got_tx.size() > 37) ? got_tx[37] : 1'b1);
        end
        checks++;
        if (fd_pulses() !== 1 || got_fd[44] !== 1'b1) begin
            errors++;
            $display("FAIL even_done got pulses=%0d want 1 at cycle 44",
                     fd_pulses());
        end
    endtask

    task automatic test_odd_short();
        int d;
        start_cap();
        push_c(5'h1F);
        @(negedge clk);
        vc = 1'b0;
        stop_cap();
        got_tx = qc_tx;
        got_fd = qc_fd;
        add_idle();
        add_frame(5'h1F, 5, 1, 2);
        d = n_diff();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL odd_wave got %0d bad samples (first %0d) want 0",
                     d, first_bad);
        end
        checks++;
        if (got_tx.size() <= 36 || got_tx[25] !== 1'b0
            || got_fd[36] !== 1'b1) begin
            errors++;
            $display("FAIL odd_short_frame got par/done wrong want par=0 done@36");
        end
    endtask

    task automatic test_back_to_back();
        int d;
        int pos[$];
        start_cap();
        push_a(8'h01);
        push_a(8'h02);
        push_a(8'h03);
        @(negedge clk);
        va = 1'b0;
        stop_cap();
        got_tx = qa_tx;
        got_fd = qa_fd;
        add_idle();
        add_frame(1, 8, 0, 1);
        add_frame(2, 8, 0, 1);
        add_frame(3, 8, 0, 1);
        d = n_diff();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL b2b_wave got %0d bad samples (first %0d) want 0",
                     d, first_bad);
        end
        foreach (got_fd[i]) if (got_fd[i]) pos.push_back(i);
        checks++;
        if (pos.size() !== 3) begin
            errors++;
            $display("FAIL b2b_pulses got %0d want 3", pos.size());
        end else begin
            checks++;
            if (pos[0] !== 40 || pos[1] - pos[0] !== 40
                || pos[2] - pos[1] !== 40) begin
                errors++;
                $display("FAIL b2b_spacing got %0d %0d %0d want 40 80 120",
                         pos[0], pos[1], pos[2]);
            end
        end
    endtask

    task automatic test_full_fifo();
        int d;
        start_cap();
        for (int v = 0; v < 5; v++) push_a(8'(v));
        #1;
        checks++;
        if (cna !== 3'd4 || ra !== 1'b0 || ba !== 1'b1) begin
            errors++;
            $display("FAIL full_state got cnt=%0d ready=%0b want 4 0",
                     cna, ra);
        end
        push_a(8'd5);
        @(negedge clk);
        va = 1'b0;
        stop_cap();
        got_tx = qa_tx;
        got_fd = qa_fd;
        add_idle();
        for (int v = 0; v < 6; v++) add_frame(v, 8, 0, 1);
        d = n_diff();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL full_order got %0d bad samples (first %0d) want 0",
                     d, first_bad);
        end
    endtask

    task automatic test_random(input int which);
        int sent[$];
        int bad;
        int w;
        start_cap();
        for (int n = 0; n < 20; n++) begin
            if (which == 0) begin
                w = int'($urandom_range(0, 255));
                push_b(8'(w));
                @(negedge clk);
                vb = 1'b0;
            end else begin
                w = int'($urandom_range(0, 31));
                push_c(5'(w));
                @(negedge clk);
                vc = 1'b0;
            end
            sent.push_back(w);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        stop_cap();
        if (which == 0) begin
            got_tx = qb_tx;
            got_fd = qb_fd;
            bad = decode(8, 2, 1);
        end else begin
            got_tx = qc_tx;
            got_fd = qc_fd;
            bad = decode(5, 1, 2);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rand%0d_framing got %0d errors want 0",
                     which, bad);
        end
        checks++;
        if (dec_q.size() !== sent.size()) begin
            errors++;
            $display("FAIL rand%0d_count got %0d want %0d",
                     which, dec_q.size(), sent.size());
        end else begin
            foreach (sent[i]) begin
                checks++;
                if (dec_q[i] !== sent[i]) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d got %0h want %0h",
                             which, i, dec_q[i], sent[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_mid_reset();
        wait_idle();
        test_even_parity();
        test_odd_short();
        test_back_to_back();
        test_full_fifo();
        test_random(0);
        test_random(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
